// File: rtl/divu_seq.sv
// rtl/divu_seq.sv - iterative unsigned restoring divider, one quotient bit per clock
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      request a divide; sampled only when not busy
//   dividend   unsigned dividend, latched on an accepted start
//   divisor    unsigned divisor, latched on an accepted start
//   busy       iteration in progress; start is ignored while high
//   done       one-cycle pulse: quotient/remainder/div_zero valid
//   quotient   result quotient, held until the next completion
//   remainder  result remainder, held until the next completion
//   div_zero   last op had divisor == 0, held with the results

module divu_seq #(
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] dividend,
    input  logic [WORD_SIZE-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] quotient,
    output logic [WORD_SIZE-1:0] remainder,
    output logic                 div_zero
);

    localparam int CW = $clog2(WORD_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state;
    logic [WORD_SIZE:0]   rem;
    logic [WORD_SIZE-1:0] quo;
    logic [WORD_SIZE-1:0] dvsr;
    logic [CW-1:0]        count;
    // A divide-by-zero is accepted on one edge and completes on the next,
    // without ever entering RUN or raising busy.
    logic                 zero_pend;

    logic [WORD_SIZE:0]   shifted;
    logic [WORD_SIZE:0]   diff;
    logic [WORD_SIZE:0]   rem_next;
    logic [WORD_SIZE-1:0] quo_next;
    logic                 last_iter;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the trial subtraction only if it did not borrow.
    always_comb begin
        shifted   = {rem[WORD_SIZE-1:0], quo[WORD_SIZE-1]};
        diff      = shifted - {1'b0, dvsr};
        rem_next  = diff[WORD_SIZE] ? shifted : diff;
        quo_next  = {quo[WORD_SIZE-2:0], ~diff[WORD_SIZE]};
        last_iter = (count == CW'(WORD_SIZE - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            count     <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            zero_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (zero_pend) begin
                        zero_pend <= 1'b0;
                        state     <= S_DONE;
                        done      <= 1'b1;
                        quotient  <= '1;
                        remainder <= quo;
                        div_zero  <= 1'b1;
                    end else if (start) begin
                        quo      <= dividend;
                        dvsr     <= divisor;
                        rem      <= '0;
                        count    <= '0;
                        div_zero <= 1'b0;
                        if (divisor != '0) begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end else begin
                            zero_pend <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= quo_next;
                        remainder <= rem_next[WORD_SIZE-1:0];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divu_seq.sv
// tb/tb_divu_seq.sv - scoreboard testbench for divu_seq (WORD_SIZE = 8)

module tb_divu_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    divu_seq #(.WORD_SIZE(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: actual q=%0d r=%0d required no completion", quotient, remainder);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("result_q %0d/%0d", e.a, e.b), 32'(quotient), 32'(e.q));
                check($sformatf("result_r %0d/%0d", e.a, e.b), 32'(remainder), 32'(e.r));
                check($sformatf("result_dz %0d/%0d", e.a, e.b), 32'(div_zero), 32'(e.dz));
                if (!e.dz) begin
                    check($sformatf("invariant %0d/%0d", e.a, e.b),
                          32'((32'(quotient) * 32'(e.b) + 32'(remainder) == 32'(e.a)) && (remainder < e.b)),
                          32'd1);
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz;
        sb.push_back(e);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
    endtask

    // Called with start already driven; returns at #1 after the done edge.
    task automatic run_to_done(input logic nonzero, input int lat_exp, input bit inject);
        int           lat;
        bit           got;
        logic [W-1:0] q_before;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        check("busy_after_accept", 32'(busy), 32'(nonzero));
        q_before = quotient;
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            if (inject && lat == 3) begin
                start    = 1'b1;
                dividend = 8'd200;
                divisor  = 8'd7;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (lat == 4 && lat_exp > 4) check("quotient_hold_midrun", 32'(quotient), 32'(q_before));
            if (done) got = 1;
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(lat_exp));
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dz,
                         input bit inject);
        @(negedge clk);
        issue(a, b, q, r, dz);
        run_to_done(b != 0, (b != 0) ? W : 1, inject);
    endtask

    task automatic check_pulse_hold(input logic [W-1:0] q, input logic [W-1:0] r);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("hold_q", 32'(quotient), 32'(q));
        check("hold_r", 32'(remainder), 32'(r));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_q", 32'(quotient), 32'd0);
        check("reset_r", 32'(remainder), 32'd0);
        check("reset_dz", 32'(div_zero), 32'd0);
        rst_n = 1'b1;

        do_op(8'd42, 8'd5, 8'd8, 8'd2, 1'b0, 0);
        check_pulse_hold(8'd8, 8'd2);
        do_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 0);
        do_op(8'd10, 8'd52, 8'd0, 8'd10, 1'b0, 0);
        do_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 0);
        do_op(8'd52, 8'd0, 8'hFF, 8'd52, 1'b1, 0);
        check_pulse_hold(8'hFF, 8'd52);

        // Start while busy must be ignored.
        do_op(8'd42, 8'd5, 8'd8, 8'd2, 1'b0, 1);
        check_pulse_hold(8'd8, 8'd2);

        // Reset in the middle of an op discards it.
        @(negedge clk);
        start = 1'b1; dividend = 8'd42; divisor = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_q", 32'(quotient), 32'd0);
        check("midreset_r", 32'(remainder), 32'd0);
        check("midreset_dz", 32'(div_zero), 32'd0);
        do_op(8'd42, 8'd5, 8'd8, 8'd2, 1'b0, 0);

        // Back-to-back: new start presented during the done cycle.
        issue(8'd100, 8'd3, 8'd33, 8'd1, 1'b0);
        run_to_done(1'b1, W, 0);
        check_pulse_hold(8'd33, 8'd1);

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = (i % 7 == 3) ? 8'd0 : W'($urandom_range(1, 255));
            if (b == 0) do_op(a, b, 8'hFF, a, 1'b1, 0);
            else        do_op(a, b, a / b, a % b, 1'b0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
